softplus_sq_sweep_capture: RTL and testbench
============================================

// Module: softplus_sq_sweep_capture
// PURPOSE
//  Self-test sweep engine for the piecewise softplus^2 approximator. Drives the operand
//  across a signed Q8.8 range and captures each (x, result) pair. Checks that the result is
//  monotonically non-decreasing. Streams captured pairs out over a valid/ready port for
//  logging or host readout. Sits beside softplus_squared: operand goes out to it, result
//  comes back.
// PARAMETERS
//  WIDTH       16       operand/result width (Q8.8)
//  START       16'hF800 first operand issued (-8.0)
//  STOP        16'h0800 last operand issued, inclusive (+8.0)
//  APPROX_LAT  0        approximator latency in cycles, 0..3 (0 = combinational)
//  FIFO_DEPTH  4        capture FIFO entries, power of two, >= 2
// PORTS
//  clock        in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-low
//  start        in   1      begin sweep; sampled only in IDLE
//  operand      out  WIDTH  operand driven to approximator
//  result       in   WIDTH  approximator output, valid APPROX_LAT cycles after operand
//  m_valid      out  1      capture stream valid
//  m_ready      in   1      capture stream ready
//  m_x          out  WIDTH  captured operand
//  m_y          out  WIDTH  captured result
//  busy         out  1      high in SWEEP and DRAIN
//  done         out  1      one-cycle pulse at sweep completion
//  mono_err     out  1      sticky: some result was lower than its predecessor
//  err_count    out  16     number of monotonicity violations, saturates at 16'hFFFF
//  sample_cnt   out  17     pairs captured this sweep
// BEHAVIOUR
//  - Reset (rst=0 at a clock edge): state IDLE. operand=START. m_valid=0, m_x=m_y=0.
//    busy=0, done=0, mono_err=0, err_count=0, sample_cnt=0. FIFO and in-flight pipe are
//    flushed. Reset mid-sweep abandons the sweep; partial data is discarded.
//  - FSM: IDLE -start-> SWEEP. SWEEP -(STOP issued)-> DRAIN.
//    DRAIN -(pipe empty and FIFO empty)-> DONE. DONE -> IDLE next cycle; done=1 only in DONE.
//  - start while busy is ignored. On IDLE->SWEEP, mono_err, err_count and sample_cnt clear.
//  - Issue (SWEEP): operand advances by one when fifo_count + inflight < FIFO_DEPTH. Credit
//    counting guarantees a capture never finds the FIFO full; no result is ever dropped.
//  - Operand increments modulo 2^WIDTH: 16'hFFFF -> 16'h0000 continues the sweep.
//    Default range yields 4097 samples.
//  - Capture: the x tag and valid bit travel an APPROX_LAT-deep shift register. At exit,
//    result is sampled with that x and pushed into the FIFO. For APPROX_LAT=0, sampling
//    happens in the issue cycle.
//  - Monotonic check is on the captured y, compared unsigned with the previous captured y.
//    The first sample of a sweep is not compared. y < prev sets mono_err and increments
//    err_count; equal is legal.
//  - Stream: m_x/m_y come from the FIFO head. An entry pops when m_valid && m_ready.
//    m_valid never drops and m_x/m_y never change while stalled. Simultaneous push and pop
//    are legal at any occupancy; the count is unchanged.
//  - sample_cnt increments on each push, so it counts captured pairs, not streamed pairs.
// TESTING
//  1 rst held low 3 cycles, then released -> all outputs at reset values; no m_valid.
//  2 start, m_ready=1, APPROX_LAT=0 -> 4097 pairs, m_x from F800 through 0800 in order.
//    done pulses once; sample_cnt=4097; mono_err=0 with an ideal softplus^2 model.
//  3 m_ready toggled randomly 50% -> identical ordered stream, no loss or duplication.
//    m_x/m_y stable while stalled.
//  4 Model returns 0x0040 at x=0x0000 and 0x0030 at x=0x0001 -> mono_err=1, err_count=1.
//  5 APPROX_LAT=3, m_ready=0 for 20 cycles -> at most FIFO_DEPTH entries held, issue
//    stalls; no drops when m_ready rises.
//  6 rst low mid-sweep at x=0xFFFF, then start -> stream restarts at F800; counters cleared.

Source files
------------

// File: rtl/softplus_sq_sweep_capture.sv
// Sweep engine for the softplus^2 approximator: issues a Q8.8 operand ramp, captures
// (x, result) pairs into a credit-protected FIFO, flags non-monotonic results.
module softplus_sq_sweep_capture #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] START      = 16'hF800,
    parameter logic [WIDTH-1:0] STOP       = 16'h0800,
    parameter int               APPROX_LAT = 0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] result,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_x,
    output logic [WIDTH-1:0] m_y,
    output logic             busy,
    output logic             done,
    output logic             mono_err,
    output logic [15:0]      err_count,
    output logic [16:0]      sample_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PL = (APPROX_LAT > 0) ? APPROX_LAT : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] operand_r;
    logic             busy_r;
    logic             done_r;
    logic             mono_err_r;
    logic [15:0]      err_count_r;
    logic [16:0]      sample_cnt_r;
    logic [WIDTH-1:0] prev_y_r;
    logic             have_prev_r;

    logic [WIDTH-1:0] mem_x_r [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_y_r [FIFO_DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    fifo_count_r;

    logic [CW-1:0]    inflight_s;
    logic [CW:0]      credit_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] exit_x_s;

    // Credit: FIFO entries plus results still in the approximator never exceed the depth
    always_comb begin
        credit_s = {1'b0, fifo_count_r} + {1'b0, inflight_s};
        issue_s  = (state_r == S_SWEEP) && (credit_s < DEPTH_C);
        pop_s    = (fifo_count_r != CW'(0)) && m_ready;
    end

    generate
        if (APPROX_LAT == 0) begin : g_comb
            assign push_s     = issue_s;
            assign exit_x_s   = operand_r;
            assign inflight_s = CW'(0);
        end else begin : g_pipe
            logic [PL-1:0]    vld_r;
            logic [WIDTH-1:0] x_r [PL];
            logic [CW-1:0]    cnt_r;

            // x tag / valid shift register aligned with the approximator latency
            always_ff @(posedge clock) begin
                if (!rst) begin
                    vld_r <= {PL{1'b0}};
                    for (int i = 0; i < PL; i++) x_r[i] <= {WIDTH{1'b0}};
                    cnt_r <= CW'(0);
                end else begin
                    vld_r[0] <= issue_s;
                    x_r[0]   <= operand_r;
                    for (int i = 1; i < PL; i++) begin
                        vld_r[i] <= vld_r[i-1];
                        x_r[i]   <= x_r[i-1];
                    end
                    cnt_r <= cnt_r + CW'(issue_s) - CW'(vld_r[PL-1]);
                end
            end

            assign push_s     = vld_r[PL-1];
            assign exit_x_s   = x_r[PL-1];
            assign inflight_s = cnt_r;
        end
    endgenerate

    // Capture FIFO storage, pointers and occupancy
    always_ff @(posedge clock) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_x_r[i] <= {WIDTH{1'b0}};
                mem_y_r[i] <= {WIDTH{1'b0}};
            end
            wptr_r       <= AW'(0);
            rptr_r       <= AW'(0);
            fifo_count_r <= CW'(0);
        end else begin
            if (push_s) begin
                mem_x_r[wptr_r] <= exit_x_s;
                mem_y_r[wptr_r] <= result;
                wptr_r          <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Sweep FSM, operand ramp and monotonicity monitor
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            operand_r    <= START;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mono_err_r   <= 1'b0;
            err_count_r  <= 16'h0000;
            sample_cnt_r <= 17'd0;
            prev_y_r     <= {WIDTH{1'b0}};
            have_prev_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r      <= S_SWEEP;
                        operand_r    <= START;
                        busy_r       <= 1'b1;
                        mono_err_r   <= 1'b0;
                        err_count_r  <= 16'h0000;
                        sample_cnt_r <= 17'd0;
                        have_prev_r  <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (issue_s) begin
                        operand_r <= operand_r + WIDTH'(1);
                        if (operand_r == STOP) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((inflight_s == CW'(0)) && (fifo_count_r == CW'(0))) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r   <= S_IDLE;
                    done_r    <= 1'b0;
                    operand_r <= START;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase

            // pushes only happen in SWEEP/DRAIN, so they never collide with the start clear
            if (push_s) begin
                sample_cnt_r <= sample_cnt_r + 17'd1;
                prev_y_r     <= result;
                have_prev_r  <= 1'b1;
                if (have_prev_r && (result < prev_y_r)) begin
                    mono_err_r <= 1'b1;
                    if (err_count_r != 16'hFFFF) begin
                        err_count_r <= err_count_r + 16'd1;
                    end
                end
            end
        end
    end

    assign operand    = operand_r;
    assign m_valid    = (fifo_count_r != CW'(0));
    assign m_x        = mem_x_r[rptr_r];
    assign m_y        = mem_y_r[rptr_r];
    assign busy       = busy_r;
    assign done       = done_r;
    assign mono_err   = mono_err_r;
    assign err_count  = err_count_r;
    assign sample_cnt = sample_cnt_r;

endmodule

// File: tb/tb_softplus_sq_sweep_capture.sv
// Directed bench for softplus_sq_sweep_capture: a combinational (LAT=0) and a 3-cycle
// (LAT=3) instance, each fed by a monotonic stand-in for softplus^2.
module tb_softplus_sq_sweep_capture;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start3 = 1'b0;
    logic        m_ready = 1'b0;
    logic        inject = 1'b0;
    logic        sel = 1'b0;

    logic [15:0] operand0, operand3, result0, result3;
    logic [15:0] m_x0, m_x3, m_y0, m_y3;
    logic        m_valid0, m_valid3, busy0, busy3, done0, done3, mono0, mono3;
    logic [15:0] err0, err3;
    logic [16:0] scnt0, scnt3;
    logic [15:0] p1 = 16'h0000, p2 = 16'h0000, p3 = 16'h0000;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    // Stand-in approximator: flat-ish ramp for x<0, x+0x40 for x>=0; optional dip at x=1
    function automatic logic [15:0] model(input logic [15:0] x, input logic inj);
        logic [15:0] t;
        if (inj && x == 16'h0001) return 16'h0030;
        if (x[15]) begin
            t = x + 16'h0800;
            return t >> 6;
        end
        return x + 16'h0040;
    endfunction

    assign result0 = model(operand0, inject);
    assign result3 = model(p3, inject);

    always @(posedge clock) begin
        p1 <= operand3;
        p2 <= p1;
        p3 <= p2;
    end

    softplus_sq_sweep_capture #(.APPROX_LAT(0)) dut0 (
        .clock(clock), .rst(rst), .start(start0), .operand(operand0), .result(result0),
        .m_valid(m_valid0), .m_ready(m_ready), .m_x(m_x0), .m_y(m_y0), .busy(busy0),
        .done(done0), .mono_err(mono0), .err_count(err0), .sample_cnt(scnt0));

    softplus_sq_sweep_capture #(.APPROX_LAT(3)) dut3 (
        .clock(clock), .rst(rst), .start(start3), .operand(operand3), .result(result3),
        .m_valid(m_valid3), .m_ready(m_ready), .m_x(m_x3), .m_y(m_y3), .busy(busy3),
        .done(done3), .mono_err(mono3), .err_count(err3), .sample_cnt(scnt3));

    logic [15:0] op, x, y, ec;
    logic        v, bz, d, me;
    logic [16:0] sc;
    assign op = sel ? operand3 : operand0;
    assign x  = sel ? m_x3 : m_x0;
    assign y  = sel ? m_y3 : m_y0;
    assign v  = sel ? m_valid3 : m_valid0;
    assign bz = sel ? busy3 : busy0;
    assign d  = sel ? done3 : done0;
    assign me = sel ? mono3 : mono0;
    assign ec = sel ? err3 : err0;
    assign sc = sel ? scnt3 : scnt0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_operand", 32'(op), 32'h0000F800);
        chk("rst_valid", 32'(v), 32'h0);
        chk("rst_mx", 32'(x), 32'h0);
        chk("rst_my", 32'(y), 32'h0);
        chk("rst_busy", 32'(bz), 32'h0);
        chk("rst_done", 32'(d), 32'h0);
        chk("rst_mono", 32'(me), 32'h0);
        chk("rst_errcnt", 32'(ec), 32'h0);
        chk("rst_samples", 32'(sc), 32'h0);
    endtask

    // mode 0: ready=1, mode 1: random ready, mode 2: ready low for the first 20 cycles
    task automatic run_sweep(input int mode, input logic exp_mono, input int exp_err,
                             input logic abort_ffff);
        logic [15:0] exp_x = 16'hF800;
        logic [15:0] hold_x = 16'h0000, hold_y = 16'h0000;
        int pairs = 0;
        logic stalled = 1'b0, finished = 1'b0, rdy;
        @(negedge clock);
        if (sel) start3 = 1'b1; else start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        start3 = 1'b0;
        chk("start_busy", 32'(bz), 32'h1);
        chk("start_samples_clr", 32'(sc), 32'h0);
        chk("start_mono_clr", 32'(me), 32'h0);
        chk("start_err_clr", 32'(ec), 32'h0);
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            if (stalled) begin
                chk("stall_valid", 32'(v), 32'h1);
                chk("stall_x", 32'(x), 32'(hold_x));
                chk("stall_y", 32'(y), 32'(hold_y));
            end
            if (mode == 2 && cyc == 20) begin
                chk("full_samples", 32'(sc), 32'd4);
                chk("full_operand", 32'(op), 32'h0000F804);
                chk("full_head_x", 32'(x), 32'h0000F800);
            end
            if (abort_ffff && op == 16'hFFFF) begin
                rst = 1'b0;
                repeat (3) @(negedge clock);
                rst = 1'b1;
                finished = 1'b1;
            end else if (d) begin
                chk("done_pairs", 32'(pairs), 32'd4097);
                chk("done_last_x", 32'(exp_x), 32'h00000801);
                chk("done_samples", 32'(sc), 32'd4097);
                chk("done_mono", 32'(me), 32'(exp_mono));
                chk("done_errcnt", 32'(ec), 32'(exp_err));
                @(negedge clock);
                chk("done_pulse_once", 32'(d), 32'h0);
                chk("idle_busy", 32'(bz), 32'h0);
                finished = 1'b1;
            end else begin
                if (mode == 1) rdy = 1'($urandom_range(0, 1));
                else if (mode == 2) rdy = (cyc >= 20);
                else rdy = 1'b1;
                m_ready = rdy;
                if (v && rdy) begin
                    chk("stream_x", 32'(x), 32'(exp_x));
                    chk("stream_y", 32'(y), 32'(model(exp_x, inject)));
                    exp_x = exp_x + 16'h0001;
                    pairs++;
                end
                stalled = v && !rdy;
                hold_x = x;
                hold_y = y;
                @(negedge clock);
            end
        end
        if (!finished) chk("sweep_timeout", 32'h0, 32'h1);
        m_ready = 1'b1;
    endtask

    initial begin
        // 1: reset held three cycles, then idle with no stream activity
        repeat (3) @(negedge clock);
        rst = 1'b1;
        sel = 1'b0;
        #1 check_reset();
        sel = 1'b1;
        #1 check_reset();
        m_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_no_valid3", 32'(v), 32'h0);
        sel = 1'b0;
        #1 chk("idle_no_valid0", 32'(v), 32'h0);

        // 2: full sweep, combinational approximator, ready always high
        run_sweep(0, 1'b0, 0, 1'b0);
        // 3: random backpressure
        run_sweep(1, 1'b0, 0, 1'b0);
        // 4: one injected dip at x=0x0001
        inject = 1'b1;
        run_sweep(0, 1'b1, 1, 1'b0);
        inject = 1'b0;
        // 5: 3-cycle approximator with the sink stalled for 20 cycles
        sel = 1'b1;
        #1 run_sweep(2, 1'b0, 0, 1'b0);
        // 6: reset mid-sweep at x=0xFFFF, then a clean restart
        sel = 1'b0;
        #1 run_sweep(0, 1'b0, 0, 1'b1);
        #1 check_reset();
        run_sweep(0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
